// File: rtl/seq_pattern_gen_pkg.sv
// rtl/seq_pattern_gen_pkg.sv - shared state encodings and width helpers for the serial pattern family
package seq_pkg;

  localparam int PAT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_t;

  // Length field must be able to hold PAT_W itself, hence the extra bit.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - load handshake and serial output bundle of the pattern generator
interface seq_pattern_gen_if
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = 4
);
  localparam int LEN_W = len_w(PAT_W);

  logic             load_valid;
  logic             load_ready;
  logic [PAT_W-1:0] load_pattern;
  logic [LEN_W-1:0] load_len;
  logic [CNT_W-1:0] repeat_n;
  logic             abort;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_pattern, load_len, repeat_n, abort,
    input  load_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  load_valid, load_pattern, load_len, repeat_n, abort,
    output load_ready, ser_out, ser_valid, busy, done
  );

endinterface

// File: rtl/seq_pattern_gen_shreg.sv
// rtl/seq_pattern_gen_shreg.sv - parallel-load, MSB-first shift register
module seq_piso_shreg #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] data,
  output logic [PAT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (shift) begin
      q <= q << 1;
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - loads a pattern, sends bits [len-1:0] MSB-first, repeats with idle gaps
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_gen_if.slave bus
);

  localparam int LEN_W  = len_w(PAT_W);
  localparam int GAP_CW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  seq_state_t       state, state_nxt;
  logic [LEN_W-1:0] bit_cnt, bit_nxt, len_q, len_nxt, len_c;
  logic [CNT_W:0]   pass_cnt, pass_nxt;
  logic [GAP_CW-1:0] gap_cnt, gap_nxt;
  logic [PAT_W-1:0] pat_al, pat_nxt, al_in, sh_q, sh_data;
  logic             sh_load, sh_shift;
  logic             so_q, so_nxt, sv_q, sv_nxt, done_q, done_nxt;
  logic             busy_q, busy_nxt, rdy_q, rdy_nxt;

  seq_piso_shreg #(.PAT_W(PAT_W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .data  (sh_data),
    .q     (sh_q)
  );

  // Left-align so pattern[len-1] lands on the shift register MSB.
  assign len_c = (bus.load_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.load_len;
  assign al_in = bus.load_pattern << (LEN_W'(PAT_W) - len_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      len_q    <= '0;
      pass_cnt <= '0;
      gap_cnt  <= '0;
      pat_al   <= '0;
      so_q     <= 1'b0;
      sv_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_nxt;
      len_q    <= len_nxt;
      pass_cnt <= pass_nxt;
      gap_cnt  <= gap_nxt;
      pat_al   <= pat_nxt;
      so_q     <= so_nxt;
      sv_q     <= sv_nxt;
      done_q   <= done_nxt;
      busy_q   <= busy_nxt;
      rdy_q    <= rdy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    len_nxt   = len_q;
    pass_nxt  = pass_cnt;
    gap_nxt   = gap_cnt;
    pat_nxt   = pat_al;
    so_nxt    = 1'b0;
    sv_nxt    = 1'b0;
    done_nxt  = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_data   = pat_al;

    case (state)
      ST_IDLE: begin
        if (bus.load_valid) begin
          if (len_c == '0) begin
            done_nxt = 1'b1;
          end else begin
            pat_nxt   = al_in;
            len_nxt   = len_c;
            sh_load   = 1'b1;
            sh_data   = al_in;
            so_nxt    = al_in[PAT_W-1];
            sv_nxt    = 1'b1;
            bit_nxt   = len_c - LEN_W'(1);
            pass_nxt  = (CNT_W+1)'(bus.repeat_n) + (CNT_W+1)'(1);
            state_nxt = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        if (bus.abort) begin
          state_nxt = ST_IDLE;
        end else if (bit_cnt != '0) begin
          sh_shift = 1'b1;
          so_nxt   = sh_q[PAT_W-2];
          sv_nxt   = 1'b1;
          bit_nxt  = bit_cnt - LEN_W'(1);
        end else if (pass_cnt > (CNT_W+1)'(1)) begin
          pass_nxt = pass_cnt - (CNT_W+1)'(1);
          if (GAP > 0) begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_CW'(GAP - 1);
          end else begin
            sh_load = 1'b1;
            so_nxt  = pat_al[PAT_W-1];
            sv_nxt  = 1'b1;
            bit_nxt = len_q - LEN_W'(1);
          end
        end else begin
          pass_nxt  = '0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (bus.abort) begin
          state_nxt = ST_IDLE;
        end else if (gap_cnt != '0) begin
          gap_nxt = gap_cnt - GAP_CW'(1);
        end else begin
          sh_load   = 1'b1;
          so_nxt    = pat_al[PAT_W-1];
          sv_nxt    = 1'b1;
          bit_nxt   = len_q - LEN_W'(1);
          state_nxt = ST_SHIFT;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
    rdy_nxt  = (state_nxt == ST_IDLE);
  end

  assign bus.ser_out    = so_q;
  assign bus.ser_valid  = sv_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.load_ready = rdy_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed table-driven bench for seq_pattern_gen
module tb_seq_pattern_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   hits  = 0;
  int   dst   = 0;

  always #5 clk = ~clk;

  seq_pattern_gen_if #(.PAT_W(8), .CNT_W(4)) bus ();

  seq_pattern_gen #(.PAT_W(8), .CNT_W(4), .GAP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    logic [3:0] rep;
    string      exp;
    string      name;
  } vec_t;

  vec_t vecs[7];

  // Moore detector for 1101 on the valid serial stream; cleared whenever ser_valid drops.
  always @(negedge clk) begin
    if (dst == 4) hits <= hits + 1;
    if (rst || !bus.ser_valid) dst <= 0;
    else case (dst)
      0: dst <= bus.ser_out ? 1 : 0;
      1: dst <= bus.ser_out ? 2 : 0;
      2: dst <= bus.ser_out ? 2 : 3;
      3: dst <= bus.ser_out ? 4 : 0;
      default: dst <= bus.ser_out ? 2 : 0;
    endcase
  end

  function automatic logic [4:0] outs();
    return {bus.ser_valid, bus.ser_out, bus.busy, bus.done, bus.load_ready};
  endfunction

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {v,o,busy,done,rdy}=%b want %b", nm, act, exp);
    end
  endtask

  task automatic start(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep);
    @(negedge clk);
    bus.load_pattern = pat;
    bus.load_len     = len;
    bus.repeat_n     = rep;
    bus.load_valid   = 1'b1;
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    byte ch;
    start(v.pat, v.len, v.rep);
    for (int c = 1; c <= v.exp.len(); c++) begin
      @(negedge clk);
      ch = v.exp[c-1];
      if (ch == 8'h2d) check($sformatf("%s c%0d", v.name, c), outs(), 5'b00100);
      else check($sformatf("%s c%0d", v.name, c), outs(), {1'b1, ch == 8'h31, 3'b100});
    end
    @(negedge clk);
    check($sformatf("%s done", v.name), outs(), 5'b00011);
    @(negedge clk);
    check($sformatf("%s idle", v.name), outs(), 5'b00001);
  endtask

  initial begin
    int   h0;
    logic [4:0] e;
    vecs[0] = '{8'h05, 4'd3,  4'd0, "101",         "single"};
    vecs[1] = '{8'h05, 4'd3,  4'd2, "101-101-101", "repeat"};
    vecs[2] = '{8'hA5, 4'd8,  4'd0, "10100101",    "full8"};
    vecs[3] = '{8'hA5, 4'd12, 4'd0, "10100101",    "clamp12"};
    vecs[4] = '{8'hC3, 4'd4,  4'd1, "0011-0011",   "low4x2"};
    vecs[5] = '{8'hFF, 4'd1,  4'd3, "1-1-1-1",     "len1x4"};
    vecs[6] = '{8'hFF, 4'd0,  4'd5, "",            "len0"};

    bus.load_valid = 1'b0; bus.load_pattern = '0; bus.load_len = '0;
    bus.repeat_n = '0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", outs(), 5'b00001);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", outs(), 5'b00001);

    foreach (vecs[i]) run_vec(vecs[i]);

    // abort on the 2nd bit of A5
    start(8'hA5, 4'd8, 4'd0);
    @(negedge clk); check("abort b1", outs(), 5'b11100);
    @(negedge clk); check("abort b2", outs(), 5'b10100);
    bus.abort = 1'b1;
    @(negedge clk); check("abort next", outs(), 5'b00001);
    bus.abort = 1'b0;
    @(negedge clk); check("abort nodone", outs(), 5'b00001);

    // async reset between edges in SHIFT
    start(8'hA5, 4'd8, 4'd0);
    repeat (3) @(negedge clk);
    check("arst pre", outs(), 5'b11100);
    #2 rst = 1'b1;
    #1 check("arst immediate", outs(), 5'b00001);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); check("arst after", outs(), 5'b00001);

    // load_valid held across done: one dead cycle between transfers
    @(negedge clk);
    bus.load_pattern = 8'h05; bus.load_len = 4'd3; bus.repeat_n = 4'd0;
    bus.load_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      case (c)
        1, 3, 5, 7: e = 5'b11100;
        2, 6:       e = 5'b10100;
        default:    e = 5'b00011;
      endcase
      check($sformatf("b2b c%0d", c), outs(), e);
      if (c == 7) bus.load_valid = 1'b0;
    end
    @(negedge clk); check("b2b idle", outs(), 5'b00001);

    // detector loopback: target 1101 vs shuffled 1011
    h0 = hits;
    start(8'h0D, 4'd4, 4'd0);
    repeat (4) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("detect target", {4'b0000, hits != h0}, 5'b00001);
    h0 = hits;
    start(8'h0B, 4'd4, 4'd1);
    repeat (12) @(negedge clk);
    check("detect shuffled", {4'b0000, hits != h0}, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
